// File: rtl/f_pc_npc.sv
// F-stage program counter with next-PC selection for a 5-stage MIPS pipeline.
// Branches and jumps resolve in D with one architectural delay slot.
module f_pc_npc #(
    parameter logic [31:0] PC_RESET = 32'h0000_3000,
    parameter logic [31:0] ADDR_LO  = 32'h0000_3000,
    parameter logic [31:0] ADDR_HI  = 32'h0000_6FFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        D_stall,
    input  logic [31:0] D_PC,
    input  logic [2:0]  D_NPCop,
    input  logic [31:0] D_CMP_result,
    input  logic [15:0] D_imm16,
    input  logic [25:0] D_imm26,
    input  logic [31:0] D_rs_data,
    output logic [31:0] F_PC,
    output logic [31:0] D_PC8,
    output logic        F_PC_err
);

    localparam logic [2:0] NPC_SEQ = 3'd0;
    localparam logic [2:0] NPC_BR  = 3'd1;
    localparam logic [2:0] NPC_J   = 3'd2;
    localparam logic [2:0] NPC_JR  = 3'd3;

    // Word offset of a branch: sign-extended immediate scaled by 4.
    function automatic logic [31:0] branch_offset(input logic [15:0] imm);
        return {{14{imm[15]}}, imm, 2'b00};
    endfunction

    // A fetch address is illegal if misaligned or outside the instruction window.
    function automatic logic addr_illegal(input logic [31:0] addr);
        return (addr[1:0] != 2'b00) || (addr < ADDR_LO) || (addr > ADDR_HI);
    endfunction

    logic [31:0] f_pc_r;
    logic        f_pc_err_r;
    logic [31:0] pc4_s;
    logic [31:0] branch_tgt_s;
    logic [31:0] jump_tgt_s;
    logic [31:0] npc_s;
    logic        npc_bad_s;

    // Candidate targets; the branch base is the delay-slot address D_PC + 4.
    always_comb begin
        pc4_s        = f_pc_r + 32'd4;
        branch_tgt_s = D_PC + 32'd4 + branch_offset(D_imm16);
        jump_tgt_s   = {D_PC[31:28], D_imm26, 2'b00};
    end

    // Next-PC select; reserved opcodes fall back to sequential fetch.
    always_comb begin
        npc_s = pc4_s;
        case (D_NPCop)
            NPC_SEQ: npc_s = pc4_s;
            NPC_BR: begin
                if (D_CMP_result != 32'd0) begin
                    npc_s = branch_tgt_s;
                end else begin
                    npc_s = pc4_s;
                end
            end
            NPC_J:   npc_s = jump_tgt_s;
            NPC_JR:  npc_s = D_rs_data;
            default: npc_s = pc4_s;
        endcase
        npc_bad_s = addr_illegal(npc_s);
    end

    // PC and sticky error flag; a stall commits nothing so a branch re-resolves later.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            f_pc_r     <= PC_RESET;
            f_pc_err_r <= 1'b0;
        end else if (!D_stall) begin
            f_pc_r     <= npc_s;
            f_pc_err_r <= f_pc_err_r | npc_bad_s;
        end else begin
            f_pc_r     <= f_pc_r;
            f_pc_err_r <= f_pc_err_r;
        end
    end

    assign F_PC     = f_pc_r;
    assign F_PC_err = f_pc_err_r;
    assign D_PC8    = D_PC + 32'd8;

endmodule

// File: tb/tb_f_pc_npc.sv
// Self-checking bench for f_pc_npc: directed scenarios plus randomized traffic
// compared against an arithmetic reference model.
module tb_f_pc_npc;

    logic        clk = 1'b0;
    logic        reset;
    logic        D_stall;
    logic [31:0] D_PC;
    logic [2:0]  D_NPCop;
    logic [31:0] D_CMP_result;
    logic [15:0] D_imm16;
    logic [25:0] D_imm26;
    logic [31:0] D_rs_data;
    logic [31:0] F_PC;
    logic [31:0] D_PC8;
    logic        F_PC_err;

    int checks = 0;
    int failures = 0;
    logic [31:0] m_pc;
    logic        m_err;

    f_pc_npc dut (
        .clk(clk), .reset(reset), .D_stall(D_stall), .D_PC(D_PC),
        .D_NPCop(D_NPCop), .D_CMP_result(D_CMP_result), .D_imm16(D_imm16),
        .D_imm26(D_imm26), .D_rs_data(D_rs_data), .F_PC(F_PC),
        .D_PC8(D_PC8), .F_PC_err(F_PC_err)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] ref_npc(input logic [31:0] fpc, input logic [31:0] dpc,
                                            input logic [2:0] op, input logic [31:0] cmp,
                                            input logic [15:0] i16, input logic [25:0] i26,
                                            input logic [31:0] rs);
        logic [31:0] off;
        off = {{16{i16[15]}}, i16};
        if (op == 3'd1 && cmp != 32'd0) return dpc + 32'd4 + off * 32'd4;
        if (op == 3'd2) return {dpc[31:28], i26, 2'b00};
        if (op == 3'd3) return rs;
        return fpc + 32'd4;
    endfunction

    function automatic bit ref_legal(input logic [31:0] a);
        return (a % 32'd4 == 32'd0) && a >= 32'h0000_3000 && a <= 32'h0000_6FFF;
    endfunction

    // Advance one rising edge, updating the model from the inputs seen at the edge.
    task automatic clock_edge();
        logic [31:0] n;
        n = ref_npc(m_pc, D_PC, D_NPCop, D_CMP_result, D_imm16, D_imm26, D_rs_data);
        @(posedge clk);
        if (!reset) begin
            m_pc  = 32'h0000_3000;
            m_err = 1'b0;
        end else if (!D_stall) begin
            m_err = m_err | !ref_legal(n);
            m_pc  = n;
        end
        #1;
    endtask

    task automatic drive(input logic [2:0] op, input logic [31:0] dpc, input logic [31:0] cmp,
                         input logic [15:0] i16, input logic [25:0] i26, input logic [31:0] rs,
                         input logic stall);
        D_NPCop = op; D_PC = dpc; D_CMP_result = cmp;
        D_imm16 = i16; D_imm26 = i26; D_rs_data = rs; D_stall = stall;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        m_pc  = 32'h0000_3000;
        m_err = 1'b0;
        drive(3'd0, 32'h0000_3000, 32'd0, 16'd0, 26'd0, 32'd0, 1'b0);
        clock_edge();
        reset = 1'b1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        m_pc  = 32'h0000_3000;
        m_err = 1'b0;
        drive(3'd0, 32'h0000_3000, 32'd0, 16'd0, 26'd0, 32'd0, 1'b0);
        repeat (2) clock_edge();
        checks++;
        if (F_PC !== 32'h0000_3000 || F_PC_err !== 1'b0) begin
            failures++;
            $display("FAIL reset_state got pc=%h err=%b exp pc=00003000 err=0", F_PC, F_PC_err);
        end
        reset = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            logic [31:0] exp;
            exp = 32'h0000_3000 + 32'd4 * i;
            clock_edge();
            checks++;
            if (F_PC !== exp || F_PC_err !== 1'b0) begin
                failures++;
                $display("FAIL reset_seq%0d got pc=%h err=%b exp pc=%h err=0", i, F_PC, F_PC_err, exp);
            end
        end
    endtask

    task automatic test_branch();
        drive(3'd3, 32'h0000_3010, 32'd0, 16'd0, 26'd0, 32'h0000_3014, 1'b0);
        clock_edge();
        drive(3'd1, 32'h0000_3010, 32'd1, 16'hFFFC, 26'd0, 32'd0, 1'b0);
        clock_edge();
        checks++;
        if (F_PC !== 32'h0000_3004) begin
            failures++;
            $display("FAIL branch_taken got=%h exp=00003004", F_PC);
        end
        drive(3'd3, 32'h0000_3010, 32'd0, 16'd0, 26'd0, 32'h0000_3014, 1'b0);
        clock_edge();
        drive(3'd1, 32'h0000_3010, 32'd0, 16'hFFFC, 26'd0, 32'd0, 1'b0);
        clock_edge();
        checks++;
        if (F_PC !== 32'h0000_3018) begin
            failures++;
            $display("FAIL branch_not_taken got=%h exp=00003018", F_PC);
        end
        checks++;
        if (F_PC_err !== 1'b0) begin
            failures++;
            $display("FAIL branch_err got=%b exp=0", F_PC_err);
        end
    endtask

    task automatic test_jump();
        drive(3'd2, 32'h0000_3020, 32'd0, 16'd0, 26'h0000C40, 32'd0, 1'b0);
        #1;
        checks++;
        if (D_PC8 !== 32'h0000_3028) begin
            failures++;
            $display("FAIL jump_link got=%h exp=00003028", D_PC8);
        end
        clock_edge();
        checks++;
        if (F_PC !== 32'h0000_3100) begin
            failures++;
            $display("FAIL jump_target got=%h exp=00003100", F_PC);
        end
    endtask

    task automatic test_jr_stall();
        drive(3'd3, 32'h0000_3100, 32'd0, 16'd0, 26'd0, 32'h0000_3200, 1'b1);
        repeat (2) begin
            clock_edge();
            checks++;
            if (F_PC !== 32'h0000_3100) begin
                failures++;
                $display("FAIL jr_stall_hold got=%h exp=00003100", F_PC);
            end
        end
        D_rs_data = 32'h0000_3300;
        D_stall   = 1'b0;
        clock_edge();
        checks++;
        if (F_PC !== 32'h0000_3300) begin
            failures++;
            $display("FAIL jr_release got=%h exp=00003300", F_PC);
        end
    endtask

    task automatic test_error();
        drive(3'd3, 32'h0000_3300, 32'd0, 16'd0, 26'd0, 32'h0000_3202, 1'b0);
        clock_edge();
        checks++;
        if (F_PC !== 32'h0000_3202 || F_PC_err !== 1'b1) begin
            failures++;
            $display("FAIL err_set got pc=%h err=%b exp pc=00003202 err=1", F_PC, F_PC_err);
        end
        D_NPCop = 3'd0;
        repeat (2) clock_edge();
        checks++;
        if (F_PC !== 32'h0000_320A || F_PC_err !== 1'b1) begin
            failures++;
            $display("FAIL err_sticky got pc=%h err=%b exp pc=0000320a err=1", F_PC, F_PC_err);
        end
        #2;
        reset = 1'b0;
        m_pc  = 32'h0000_3000;
        m_err = 1'b0;
        #1;
        checks++;
        if (F_PC !== 32'h0000_3000 || F_PC_err !== 1'b0) begin
            failures++;
            $display("FAIL err_async_clear got pc=%h err=%b exp pc=00003000 err=0", F_PC, F_PC_err);
        end
        clock_edge();
        reset = 1'b1;
    endtask

    task automatic test_wrap();
        do_reset();
        drive(3'd3, 32'h0000_3000, 32'd0, 16'd0, 26'd0, 32'hFFFF_FFFC, 1'b0);
        clock_edge();
        D_NPCop = 3'd0;
        clock_edge();
        checks++;
        if (F_PC !== 32'h0000_0000 || F_PC_err !== 1'b1) begin
            failures++;
            $display("FAIL wrap got pc=%h err=%b exp pc=00000000 err=1", F_PC, F_PC_err);
        end
        drive(3'd0, 32'hFFFF_FFFC, 32'd0, 16'd0, 26'd0, 32'd0, 1'b0);
        #1;
        checks++;
        if (D_PC8 !== 32'h0000_0004) begin
            failures++;
            $display("FAIL link_wrap got=%h exp=00000004", D_PC8);
        end
        do_reset();
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            logic [31:0] dpc;
            logic [31:0] rs;
            dpc = 32'h0000_3000 + 32'd4 * $urandom_range(0, 32'hFFF);
            rs  = ($urandom_range(0, 3) != 0) ? 32'h0000_3000 + 32'd4 * $urandom_range(0, 32'hFFF)
                                              : $urandom;
            drive(3'($urandom_range(0, 7)), dpc,
                  ($urandom_range(0, 1) != 0) ? 32'($urandom) | 32'd1 : 32'd0,
                  16'($urandom), 26'($urandom), rs, ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 24) == 0) begin
                reset = 1'b0;
                m_pc  = 32'h0000_3000;
                m_err = 1'b0;
            end else begin
                reset = 1'b1;
            end
            #1;
            checks++;
            if (D_PC8 !== dpc + 32'd8) begin
                failures++;
                $display("FAIL rand_link[%0d] got=%h exp=%h", i, D_PC8, dpc + 32'd8);
            end
            clock_edge();
            checks++;
            if (F_PC !== m_pc || F_PC_err !== m_err) begin
                failures++;
                $display("FAIL rand_pc[%0d] got pc=%h err=%b exp pc=%h err=%b",
                         i, F_PC, F_PC_err, m_pc, m_err);
            end
        end
        reset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_branch();
        test_jump();
        test_jr_stall();
        test_error();
        test_wrap();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
